// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, divisor tick generator, oversampling
// start/data/stop FSM and a first-word-fall-through FIFO for received words.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NTICKS     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx,
    input  logic [10:0]           divisor,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  rx_empty,
    output logic                  rx_full,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int unsigned SW = $clog2(NTICKS);
    localparam int unsigned NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [SW-1:0] S_HALF = SW'(NTICKS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(NTICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic                  rx_q1, rx_s;
    logic [10:0]           tick_cnt;
    logic                  tick;
    state_t                state, state_n;
    logic [SW-1:0]         s_cnt, s_n;
    logic [NW-1:0]         n_cnt, n_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic                  push, ferr;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count;
    logic                  do_pop, do_push;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= rx;
            rx_s  <= rx_q1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)               tick_cnt <= '0;
        else if (tick_cnt == divisor) tick_cnt <= '0;
        else                        tick_cnt <= tick_cnt + 11'd1;
    end

    assign tick = (tick_cnt == divisor);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            s_cnt <= '0;
            n_cnt <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            s_cnt <= s_n;
            n_cnt <= n_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s_cnt;
        n_n     = n_cnt;
        shreg_n = shreg;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt == S_HALF) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s_cnt + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt == S_LAST) begin
                        shreg_n = {rx_s, shreg[DATA_WIDTH-1:1]};
                        s_n     = '0;
                        if (n_cnt == N_LAST) state_n = STOP;
                        else                 n_n = n_cnt + NW'(1);
                    end else begin
                        s_n = s_cnt + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_cnt == S_LAST) begin
                        state_n = IDLE;
                        s_n     = '0;
                    end else begin
                        s_n = s_cnt + SW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        push = 1'b0;
        ferr = 1'b0;
        if (state == STOP && tick && s_cnt == S_LAST) begin
            push = rx_s;
            ferr = !rx_s;
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
    assign rx_empty = (count == '0);
    assign rx_full  = (count == C_FULL);
    assign do_pop   = rden && !rx_empty;
    assign do_push  = push && (!rx_full || do_pop);
    assign r_data   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= push && rx_full && !do_pop;
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART path. Samples a single asynchronous `rx` line with an NTICKS-times oversampling clock from its own divisor-based tick generator. Assembles one start bit, DATA_WIDTH data bits (LSB first) and one stop bit into a word, then buffers received words in a first-word-fall-through FIFO. It is the receiving end of the same frame format the UART transmit path produces, and feeds the bridge's read side.

## Interface
- DATA_WIDTH, 32, data bits per frame and FIFO word width.
- FIFO_DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- NTICKS, 16, oversampling ticks per bit; must be even, at least 4.
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  reset; synchronous, active-low.
- rx  input  1  asynchronous serial line; idles high.
- divisor  input  11  baud tick divisor; tick period is divisor+1 clocks.
- rden  input  1  pop request; ignored while rx_empty=1.
- r_data  output  DATA_WIDTH  FIFO head word; valid only while rx_empty=0.
- rx_empty  output  1  FIFO empty.
- rx_full  output  1  FIFO holds FIFO_DEPTH words.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: word completed while FIFO full and not popped.

## Operation
- Synchronizer: two flops on rx. Both reset to 1. FSM uses only the synchronized value rx_s.
- Tick generator:
  - 11-bit counter increments every clock.
  - When counter == divisor, tick=1 for that cycle and counter returns to 0.
  - divisor=0 gives a tick every clock.
  - divisor is sampled live; changing it mid-frame is unsupported.
- FSM has states IDLE, START, DATA, STOP. It has a tick counter s (width for NTICKS) and a bit counter n (width for DATA_WIDTH).
  - IDLE: when rx_s==0 (no tick needed), go to START with s=0.
  - START: on each tick, if s==NTICKS/2-1, check rx_s:
    - rx_s==0: go to DATA with s=0, n=0.
    - Otherwise: go to IDLE (glitch rejected, nothing reported).
    - On other ticks, s++.
  - DATA: on each tick, if s==NTICKS-1:
    - Shift right, with rx_s entering the MSB, so the first bit ends at bit 0. Set s=0.
    - If n==DATA_WIDTH-1, go to STOP; otherwise n++.
    - On other ticks, s++.
  - STOP: on each tick, if s==NTICKS-1:
    - rx_s==1: push the shift register into the FIFO.
    - rx_s==0: pulse frame_err and discard the word.
    - Go to IDLE in either case. On other ticks, s++.
- FIFO:
  - Read pointer, write pointer and count are reset. Storage is not reset.
  - r_data = mem[rd_ptr] combinationally.
  - Push while full and rden=0: word dropped, overrun pulses, contents unchanged.
  - Push while full with rden=1 in the same cycle: pop and push both succeed, no overrun.
  - rden while empty: no effect, including when a push happens in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: FSM returns to IDLE, the partial word is lost and the FIFO is emptied. No pulses are generated on exit from reset.

## Timing
- Reset values:
  - rx_empty=1, rx_full=0, frame_err=0, overrun=0.
  - r_data is don't-care.
  - State IDLE, s=n=0, shift register 0, tick counter 0.
- IDLE-to-START detection occurs on the clock after rx_s falls. That is 2–3 clocks after the rx edge, due to the synchronizer.
- Sample points:
  - Start bit: mid-bit (NTICKS/2 ticks after detection).
  - Data and stop bits: every NTICKS ticks thereafter.
- Push is registered on the clock edge that consumes the final stop-bit tick. On the next cycle rx_empty=0 and r_data shows the word.
- frame_err and overrun are registered and assert on the same edge a push would have occurred. Each is high for exactly one clock.
- A new start bit is accepted on the first clock after returning to IDLE, so back-to-back frames are received without loss.
- Pop: rden=1 at edge k; r_data and flags reflect the new head after edge k.

## Test plan
- Single frame: divisor=0, NTICKS=16, drive 0xA5A51234 LSB first at 16 clocks/bit with stop=1 -> rx_empty falls, r_data=0xA5A51234, frame_err=0; rden once -> rx_empty=1.
- Glitch rejection: rx low for 5 clocks, then high -> FSM returns to IDLE, rx_empty stays 1, no pulses.
- Framing error: send 0x0000FFFF with stop bit low -> frame_err high one cycle, rx_empty stays 1. A following valid frame 0x12345678 is received correctly.
- Overrun: send 0x1, 0x2, 0x3, 0x4, 0x5 back-to-back without rden:
  - rx_full=1 after the 4th frame.
  - overrun pulses once on the 5th.
  - Four pops return 1, 2, 3, 4 in order.
- Full with simultaneous pop: FIFO full, rden asserted on the 5th-frame push cycle -> no overrun, pops return 2, 3, 4, 5.
- Reset mid-frame: reset_n low for 1 clock during DATA bit 10 -> rx_empty=1, no pulses. A next complete frame 0xDEADBEEF is received correctly. Repeat with divisor=3 (64 clocks/bit).
